// File: rtl/mac_valid_pipeline.sv
// mac_valid_pipeline
//   Tracks the valid bit and tag of each op in flight through the MAC
//   datapath. MAC ops take MAC_LAT cycles and multiply-only ops take
//   MUL_LAT cycles. The block supports stalls, a synchronous flush,
//   issue back-pressure and an occupancy count for the issue controller.
//
// Ports
//   clk        rising-edge clock
//   aclr       asynchronous reset, active-high
//   en         pipeline advance enable (0 holds all state)
//   flush      synchronous flush of every valid bit
//   in_valid   issue request
//   in_mode    0 = MAC op (MAC_LAT), 1 = multiply-only op (MUL_LAT)
//   in_tag     tag travelling with the op
//   in_ready   issue accepted this cycle when in_valid=1 (combinational)
//   out_valid  exit slot holds a valid op (registered)
//   out_nop    inverse of out_valid, for legacy NOPOut consumers
//   out_tag    tag of the op in the exit slot (registered)
//   occupancy  number of valid ops in flight (registered)
module mac_valid_pipeline #(
  parameter int MAC_LAT = 7,
  parameter int MUL_LAT = 5,
  parameter int TAG_W   = 4
) (
  input  logic                             clk,
  input  logic                             aclr,
  input  logic                             en,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic                             in_mode,
  input  logic [TAG_W-1:0]                 in_tag,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic                             out_nop,
  output logic [TAG_W-1:0]                 out_tag,
  output logic [$clog2(MAC_LAT+1)-1:0]     occupancy
);

  localparam int LAST  = MAC_LAT - 1;
  // Stage where multiply-only ops enter, so that they still exit from the last stage.
  localparam int D     = MAC_LAT - MUL_LAT;
  // Stage feeding the MUL injection point; this index is only meaningful when D > 0.
  localparam int GUARD = (D > 0) ? D - 1 : 0;
  localparam int OCC_W = $clog2(MAC_LAT + 1);

  logic [MAC_LAT-1:0] v;
  logic [TAG_W-1:0]   tag [MAC_LAT];

  logic inj_mul;
  logic mul_blocked;
  logic accept;

  // A multiply-only op uses the mid-pipe injection point only when the two
  // latencies differ. When they are equal, both modes enter at stage 0.
  assign inj_mul     = (D > 0) && in_mode;

  // An older MAC op about to shift into the MUL injection stage owns that slot.
  // In that case the MUL op is refused and must be reissued later.
  assign mul_blocked = inj_mul && v[GUARD];
  assign in_ready    = en & ~flush & ~mul_blocked;
  assign accept      = in_valid & in_ready;

  assign out_valid   = v[LAST];
  assign out_nop     = ~v[LAST];
  assign out_tag     = tag[LAST];

  // Shift register of {valid, tag}.
  // Flush clears only the valid bits; stale tags are harmless because
  // nothing reads a tag without its valid bit.
  // Occupancy tracks accepts minus retirements, so it always equals the
  // number of set valid bits.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < MAC_LAT; i++) begin
        tag[i] <= '0;
      end
    end else if (flush) begin
      v         <= '0;
      occupancy <= '0;
    end else if (en) begin
      for (int i = LAST; i > 0; i--) begin
        v[i]   <= v[i-1];
        tag[i] <= tag[i-1];
      end
      v[0] <= 1'b0;
      if (accept) begin
        if (inj_mul) begin
          v[D]   <= 1'b1;
          tag[D] <= in_tag;
        end else begin
          v[0]   <= 1'b1;
          tag[0] <= in_tag;
        end
      end
      occupancy <= occupancy + OCC_W'(accept) - OCC_W'(v[LAST]);
    end
  end

endmodule

// File: tb/tb_mac_valid_pipeline.sv
// tb_mac_valid_pipeline
//   Scoreboard bench for mac_valid_pipeline.
//   dut1 uses the default parameters (7/5/4).
//   dut2 uses equal latencies (4/4) with an 8-bit tag.
//   The stimulus pushes the expected exit edge and tag of each op it issues.
//   Each monitor compares the output against the head of its queue on every
//   falling edge.
module tb_mac_valid_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aclr;

  logic       en1, flush1, in_valid1, in_mode1;
  logic [3:0] in_tag1;
  logic       in_ready1, out_valid1, out_nop1;
  logic [3:0] out_tag1;
  logic [2:0] occ1;

  logic       en2, flush2, in_valid2, in_mode2;
  logic [7:0] in_tag2;
  logic       in_ready2, out_valid2, out_nop2;
  logic [7:0] out_tag2;
  logic [2:0] occ2;

  mac_valid_pipeline dut1 (
    .clk(clk), .aclr(aclr), .en(en1), .flush(flush1),
    .in_valid(in_valid1), .in_mode(in_mode1), .in_tag(in_tag1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_nop(out_nop1),
    .out_tag(out_tag1), .occupancy(occ1)
  );

  mac_valid_pipeline #(.MAC_LAT(4), .MUL_LAT(4), .TAG_W(8)) dut2 (
    .clk(clk), .aclr(aclr), .en(en2), .flush(flush2),
    .in_valid(in_valid2), .in_mode(in_mode2), .in_tag(in_tag2),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_nop(out_nop2),
    .out_tag(out_tag2), .occupancy(occ2)
  );

  typedef struct {
    int         exitEdge;
    logic [7:0] tag;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   checks  = 0;
  int   errors  = 0;
  int   edgeCnt = 0;
  int   base    = 0;

  // Count rising edges. At each falling edge, edgeCnt holds the number of the
  // rising edge just taken.
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, edgeCnt);
    end
  endtask

  // Insert in exit-edge order, because a MUL op may overtake an older MAC op.
  task automatic pushExpected(input int which, input int exitAbs, input logic [7:0] t);
    exp_t item;
    int   idx;
    item.exitEdge = exitAbs;
    item.tag      = t;
    if (which == 1) begin
      idx = q1.size();
      for (int i = 0; i < q1.size(); i++) begin
        if (q1[i].exitEdge > exitAbs) begin
          idx = i;
          break;
        end
      end
      q1.insert(idx, item);
    end else begin
      idx = q2.size();
      for (int i = 0; i < q2.size(); i++) begin
        if (q2[i].exitEdge > exitAbs) begin
          idx = i;
          break;
        end
      end
      q2.insert(idx, item);
    end
  endtask

  // Drive one cycle on the selected DUT and keep the other one idle.
  // expExit is the test-relative edge after which the op should appear;
  // 0 means no output is expected from this issue.
  task automatic applyStimulus(input int which, input logic v, input logic m, input logic [7:0] t,
                               input logic e, input logic f, input logic expRdy, input int expExit);
    if (which == 1) begin
      in_valid1 = v; in_mode1 = m; in_tag1 = t[3:0]; en1 = e; flush1 = f;
      in_valid2 = 1'b0; in_mode2 = 1'b0; in_tag2 = '0; en2 = 1'b1; flush2 = 1'b0;
    end else begin
      in_valid2 = v; in_mode2 = m; in_tag2 = t; en2 = e; flush2 = f;
      in_valid1 = 1'b0; in_mode1 = 1'b0; in_tag1 = '0; en1 = 1'b1; flush1 = 1'b0;
    end
    #1;
    if (which == 1) checkOutput("in_ready1", in_ready1, expRdy);
    else            checkOutput("in_ready2", in_ready2, expRdy);
    if (v && expRdy && expExit > 0) pushExpected(which, base + expExit, t);
    @(negedge clk);
  endtask

  task automatic idleCycles(input int which, input int n);
    repeat (n) applyStimulus(which, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0);
  endtask

  // Monitor for dut1: out_valid must be high exactly on the expected exit edges.
  always @(negedge clk) begin : mon1
    logic expV;
    expV = (q1.size() > 0) && (q1[0].exitEdge == edgeCnt);
    checkOutput("out_valid1", out_valid1, expV);
    checkOutput("out_nop1", out_nop1, !expV);
    if (expV) begin
      checkOutput("out_tag1", out_tag1, {4'h0, q1[0].tag[3:0]});
      void'(q1.pop_front());
    end
  end

  // Monitor for dut2.
  always @(negedge clk) begin : mon2
    logic expV;
    expV = (q2.size() > 0) && (q2[0].exitEdge == edgeCnt);
    checkOutput("out_valid2", out_valid2, expV);
    checkOutput("out_nop2", out_nop2, !expV);
    if (expV) begin
      checkOutput("out_tag2", out_tag2, q2[0].tag);
      void'(q2.pop_front());
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    aclr = 1'b1;
    en1 = 1'b1; flush1 = 1'b0; in_valid1 = 1'b0; in_mode1 = 1'b0; in_tag1 = '0;
    en2 = 1'b1; flush2 = 1'b0; in_valid2 = 1'b0; in_mode2 = 1'b0; in_tag2 = '0;
    #1;
    checkOutput("rst_out_valid1", out_valid1, 0);
    checkOutput("rst_out_nop1", out_nop1, 1);
    checkOutput("rst_out_tag1", out_tag1, 0);
    checkOutput("rst_occ1", occ1, 0);
    checkOutput("rst_out_valid2", out_valid2, 0);
    checkOutput("rst_out_nop2", out_nop2, 1);
    checkOutput("rst_out_tag2", out_tag2, 0);
    checkOutput("rst_occ2", occ2, 0);
    repeat (2) @(negedge clk);
    aclr = 1'b0;

    // One MAC op, tag 3: it exits after edge 7.
    base = edgeCnt;
    applyStimulus(1, 1, 0, 8'h03, 1, 0, 1, 7);
    checkOutput("t1_occ_e1", occ1, 1);
    idleCycles(1, 5);
    checkOutput("t1_occ_e6", occ1, 1);
    idleCycles(1, 1);
    checkOutput("t1_occ_e7", occ1, 1);
    idleCycles(1, 1);
    checkOutput("t1_occ_e8", occ1, 0);
    idleCycles(1, 2);

    // Multiply-only op, tag 5: it exits after edge 5.
    base = edgeCnt;
    applyStimulus(1, 1, 1, 8'h05, 1, 0, 1, 5);
    idleCycles(1, 6);

    // MUL collides with an older MAC at edge 3 and is refused; the reissue is accepted.
    base = edgeCnt;
    applyStimulus(1, 1, 0, 8'h01, 1, 0, 1, 7);
    idleCycles(1, 1);
    applyStimulus(1, 1, 1, 8'h02, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 8'h02, 1, 0, 1, 8);
    checkOutput("t2_occ_e4", occ1, 2);
    idleCycles(1, 6);

    // Back-to-back MAC stream, tags 0..9: occupancy saturates at 7.
    base = edgeCnt;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1, 0, 8'(i), 1, 0, 1, 7 + i);
      if (i >= 6) checkOutput("t3_occ_sat", occ1, 7);
    end
    idleCycles(1, 7);
    checkOutput("t3_occ_drain", occ1, 0);

    // Stall for edges 3..5: the MAC op exits after edge 10 instead of edge 7.
    base = edgeCnt;
    applyStimulus(1, 1, 0, 8'h0A, 1, 0, 1, 10);
    idleCycles(1, 1);
    repeat (3) applyStimulus(1, 1, 0, 8'h0B, 0, 0, 0, 0);
    checkOutput("t4_occ_stall", occ1, 1);
    idleCycles(1, 7);

    // Three ops in flight, then flush together with an issue request.
    base = edgeCnt;
    applyStimulus(1, 1, 0, 8'h0C, 1, 0, 1, 0);
    applyStimulus(1, 1, 0, 8'h0D, 1, 0, 1, 0);
    applyStimulus(1, 1, 0, 8'h0E, 1, 0, 1, 0);
    checkOutput("t5_occ_pre", occ1, 3);
    applyStimulus(1, 1, 0, 8'h0F, 1, 1, 0, 0);
    checkOutput("t5_occ_flush", occ1, 0);
    idleCycles(1, 10);

    // Equal latencies: both modes exit after 4 edges and a MUL op is never refused.
    base = edgeCnt;
    applyStimulus(2, 1, 1, 8'h81, 1, 0, 1, 4);
    applyStimulus(2, 1, 0, 8'h42, 1, 0, 1, 5);
    applyStimulus(2, 1, 1, 8'h13, 1, 0, 1, 6);
    idleCycles(2, 3);
    applyStimulus(2, 1, 1, 8'h77, 1, 0, 1, 10);
    applyStimulus(2, 1, 0, 8'h88, 1, 0, 1, 11);
    applyStimulus(2, 1, 1, 8'h99, 1, 0, 1, 12);
    applyStimulus(2, 1, 0, 8'hAA, 1, 0, 1, 13);
    checkOutput("t6_occ_pre", occ2, 4);

    // Asynchronous reset between edges, while tag 0x77 is on the output.
    #1 aclr = 1'b1;
    q2.delete();
    #1;
    checkOutput("t6_rst_out_valid", out_valid2, 0);
    checkOutput("t6_rst_out_nop", out_nop2, 1);
    checkOutput("t6_rst_occ", occ2, 0);
    checkOutput("t6_rst_out_tag", out_tag2, 0);
    #1 aclr = 1'b0;
    base = edgeCnt;
    applyStimulus(2, 1, 0, 8'h5A, 1, 0, 1, 4);
    checkOutput("t6_occ_first", occ2, 1);
    idleCycles(2, 5);

    checkOutput("q1_drained", q1.size(), 0);
    checkOutput("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
